pipelined_decode_stage: RTL
===========================

Name: pipelined_decode_stage

Overview:
- Decode stage for the pipelined core, replacing the single-cycle decoder.
- Contains an internal XLEN-wide register file with write-through bypass and full RV32I immediate/control decode, including AUIPC.
- Results are held in a registered ID/EX output stage with valid/ready handshakes on both sides.
- Detects load-use hazards, stalls IF and inserts a bubble; supports a branch flush.

Parameters:
XLEN, 32, datapath/register width; immediates sign-extended from 32 to XLEN
NUM_REGS, 32, architectural registers; x0 hardwired 0; address width fixed at 5

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
if_valid  in  1  IF presents instruction
if_instr  in  32  instruction word
if_pc  in  XLEN  PC of instruction
id_ready  out  1  ID accepts this cycle (combinational)
flush  in  1  kill ID/EX contents and incoming instruction
wb_we  in  1  register write enable
wb_rd  in  5  write destination
wb_data  in  XLEN  write data
ex_valid  out  1  ID/EX register holds a valid instruction
ex_ready  in  1  EX consumes ID/EX this cycle
ex_pc  out  XLEN  registered PC
ex_rs1_val  out  XLEN  registered rs1 value
ex_rs2_val  out  XLEN  registered rs2 value
ex_imm  out  XLEN  registered immediate
ex_rd  out  5  registered destination
ex_alu_op_base  out  3  funct3; 0 for load/store/LUI/AUIPC/JAL
ex_alu_op_ext  out  7  funct7 for OP and OP-IMM shifts, else 0
ex_ctrl  out  8  {illegal, alu_src, is_jump, is_branch, mem_write, mem_read, reg_write_from_load, reg_write}, bit7..bit0

Behaviour:
- Reset (async, rst=1): ex_valid=0, all ex_* outputs 0, all registers 0.
- Decode classes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, SYSTEM 1110011.
- reg_write=0 for BRANCH, STORE, SYSTEM. is_jump=1 for JAL and JALR. alu_src=1 for OP-IMM, LOAD, STORE, JALR, AUIPC, LUI.
- Immediates:
  - I-type: sign-extended [31:20].
  - OP-IMM shifts (funct3 1/5): zero-extended [24:20].
  - S, B, J, U: standard RISC-V encodings.
  - All other classes: 0.
- Register read:
  - x0 always reads 0.
  - If wb_we && wb_rd!=0 && wb_rd==rsN, read returns wb_data in the same cycle (write-through).
  - Writes to x0 are ignored.
- rs usage: rs1 used by all classes except LUI, AUIPC, JAL. rs2 used by OP, STORE, BRANCH.
- hazard = ex_valid && ex_ctrl[1] && ex_rd!=0 && if_valid && (used rs1==ex_rd || used rs2==ex_rd).
- id_ready = !flush && !hazard && (!ex_valid || ex_ready).
- Next-state on clk, in priority order:
  1. flush: ex_valid<=0.
  2. if_valid && id_ready: load the decoded bundle; ex_valid<=1.
  3. hazard && ex_ready: bubble, ex_valid<=0, other ex_* unchanged.
  4. ex_ready: ex_valid<=0.
  5. else: hold.
- Latency: one cycle from accept to ex_valid. Throughput is one instruction per cycle with no hazards. Each load-use costs exactly one bubble.
- ex_* outputs stay stable while ex_valid && !ex_ready.
- A register write in the same cycle as accept is reflected in the captured rs values through the bypass.

Optional Feature:
- Macro: DECODE_ILLEGAL_EN.
- Defined: ex_ctrl[7]=1 for an unlisted opcode, for OP with funct7 not in {0000000, 0100000}, or for funct7=0100000 with funct3 not in {0, 5}. When illegal is set, reg_write, mem_read and mem_write are forced to 0.
- Undefined: ex_ctrl[7] is tied to 0 and no suppression is applied.

Test Plan:
- Reset, then wb x5=0x1234 and accept add x6,x5,x5 (0x00528333) → ex_rs1_val=ex_rs2_val=0x1234, ex_rd=6, ex_ctrl[0]=1.
- lw x7,8(x1) followed by add x8,x7,x2 with ex_ready=1 → id_ready=0 for exactly one cycle, one bubble (ex_valid=0), then add issues.
- addi x3,x0,-1 (0xFFF00193) → ex_imm=0xFFFFFFFF. slli x3,x3,31 → ex_imm=31, ex_alu_op_ext=0.
- wb_we x9=0xAA in the same cycle as accept of or x10,x9,x0 → ex_rs1_val=0xAA. wb to x0 followed by a read of x0 → 0.
- ex_ready=0 for 3 cycles with if_valid=1 → ex_* stable and id_ready=0 throughout. flush asserted → ex_valid=0 next cycle.
- With DECODE_ILLEGAL_EN, opcode 0x7F → ex_ctrl[7]=1 and ex_ctrl[0]=0.

Source files
------------

// File: rtl/pipelined_decode_stage.sv
// pipelined_decode_stage: RV32I decode stage with an internal register file,
// write-through bypass, load-use hazard stall and a registered ID/EX stage
// with valid/ready handshakes on both sides.
// Optional feature macro: DECODE_ILLEGAL_EN (flags illegal encodings and
// suppresses their architectural side effects).
module pipelined_decode_stage #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_alu_op_base,
    output logic [6:0]      ex_alu_op_ext,
    output logic [7:0]      ex_ctrl
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Immediates are built at 32 bits and then sign-extended to the datapath width
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic signed [31:0] s;
        s = v;
        return XLEN'(s);
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rdIdx;
    logic [4:0] rs1Idx;
    logic [4:0] rs2Idx;

    assign opcode = if_instr[6:0];
    assign rdIdx  = if_instr[11:7];
    assign funct3 = if_instr[14:12];
    assign rs1Idx = if_instr[19:15];
    assign rs2Idx = if_instr[24:20];
    assign funct7 = if_instr[31:25];

    logic [31:0] immI;
    logic [31:0] immS;
    logic [31:0] immB;
    logic [31:0] immJ;
    logic [31:0] immU;

    assign immI = {{20{if_instr[31]}}, if_instr[31:20]};
    assign immS = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign immB = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
    assign immJ = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
    assign immU = {if_instr[31:12], 12'b0};

    // Architectural register state and the ID/EX pipeline register
    logic [XLEN-1:0] regs_q [NUM_REGS];

    logic            exValid_q, exValid_d;
    logic [XLEN-1:0] exPc_q, exPc_d;
    logic [XLEN-1:0] exRs1_q, exRs1_d;
    logic [XLEN-1:0] exRs2_q, exRs2_d;
    logic [XLEN-1:0] exImm_q, exImm_d;
    logic [4:0]      exRd_q, exRd_d;
    logic [2:0]      exOpBase_q, exOpBase_d;
    logic [6:0]      exOpExt_q, exOpExt_d;
    logic [7:0]      exCtrl_q, exCtrl_d;

    logic illegalD;

`ifdef DECODE_ILLEGAL_EN
    // Flag unknown opcodes and OP encodings outside the RV32I base set
    always_comb begin
        illegalD = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_SYSTEM: illegalD = 1'b0;
            default: illegalD = 1'b1;
        endcase
        if (opcode == OPC_OP) begin
            if (funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
                illegalD = 1'b1;
            end
            if (funct7 == 7'b0100000 && funct3 != 3'd0 && funct3 != 3'd5) begin
                illegalD = 1'b1;
            end
        end
    end
`else
    assign illegalD = 1'b0;
`endif

    logic            regWrite, fromLoad, memRead, memWrite;
    logic            isBranch, isJump, aluSrc;
    logic            useRs1, useRs2;
    logic [XLEN-1:0] immD;
    logic [2:0]      opBaseD;
    logic [6:0]      opExtD;
    logic [7:0]      ctrlD;

    // Per-class control, immediate selection and source-register usage
    always_comb begin
        regWrite = 1'b0;
        fromLoad = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        isBranch = 1'b0;
        isJump   = 1'b0;
        aluSrc   = 1'b0;
        useRs1   = 1'b1;
        useRs2   = 1'b0;
        immD     = '0;
        opBaseD  = funct3;
        opExtD   = '0;
        case (opcode)
            OPC_LUI: begin
                regWrite = 1'b1;
                aluSrc   = 1'b1;
                useRs1   = 1'b0;
                immD     = sext32(immU);
                opBaseD  = 3'd0;
            end
            OPC_AUIPC: begin
                regWrite = 1'b1;
                aluSrc   = 1'b1;
                useRs1   = 1'b0;
                immD     = sext32(immU);
                opBaseD  = 3'd0;
            end
            OPC_JAL: begin
                regWrite = 1'b1;
                isJump   = 1'b1;
                useRs1   = 1'b0;
                immD     = sext32(immJ);
                opBaseD  = 3'd0;
            end
            OPC_JALR: begin
                regWrite = 1'b1;
                isJump   = 1'b1;
                aluSrc   = 1'b1;
                immD     = sext32(immI);
            end
            OPC_BRANCH: begin
                isBranch = 1'b1;
                useRs2   = 1'b1;
                immD     = sext32(immB);
            end
            OPC_LOAD: begin
                regWrite = 1'b1;
                fromLoad = 1'b1;
                memRead  = 1'b1;
                aluSrc   = 1'b1;
                immD     = sext32(immI);
                opBaseD  = 3'd0;
            end
            OPC_STORE: begin
                memWrite = 1'b1;
                aluSrc   = 1'b1;
                useRs2   = 1'b1;
                immD     = sext32(immS);
                opBaseD  = 3'd0;
            end
            OPC_OPIMM: begin
                regWrite = 1'b1;
                aluSrc   = 1'b1;
                if (funct3 == 3'd1 || funct3 == 3'd5) begin
                    immD   = XLEN'(rs2Idx);
                    opExtD = funct7;
                end else begin
                    immD = sext32(immI);
                end
            end
            OPC_OP: begin
                regWrite = 1'b1;
                useRs2   = 1'b1;
                opExtD   = funct7;
            end
            OPC_SYSTEM: begin
                immD = sext32(immI);
            end
            default: begin
                regWrite = 1'b0;
            end
        endcase
        ctrlD = {illegalD, aluSrc, isJump, isBranch,
                 memWrite && !illegalD, memRead && !illegalD,
                 fromLoad, regWrite && !illegalD};
    end

    logic [XLEN-1:0] rs1Val, rs2Val;

    // Register read with x0 forced to zero and same-cycle write-back bypass
    always_comb begin
        rs1Val = '0;
        rs2Val = '0;
        if (rs1Idx != 5'd0) begin
            if (wb_we && wb_rd == rs1Idx) rs1Val = wb_data;
            else                          rs1Val = regs_q[rs1Idx];
        end
        if (rs2Idx != 5'd0) begin
            if (wb_we && wb_rd == rs2Idx) rs2Val = wb_data;
            else                          rs2Val = regs_q[rs2Idx];
        end
    end

    logic hazard;

    assign hazard = exValid_q && exCtrl_q[1] && (exRd_q != 5'd0) && if_valid &&
                    ((useRs1 && rs1Idx == exRd_q) || (useRs2 && rs2Idx == exRd_q));

    assign id_ready = !flush && !hazard && (!exValid_q || ex_ready);

    // ID/EX next state: flush wins, then accept, then drain (a load-use bubble is a drain with no accept)
    always_comb begin
        exValid_d  = exValid_q;
        exPc_d     = exPc_q;
        exRs1_d    = exRs1_q;
        exRs2_d    = exRs2_q;
        exImm_d    = exImm_q;
        exRd_d     = exRd_q;
        exOpBase_d = exOpBase_q;
        exOpExt_d  = exOpExt_q;
        exCtrl_d   = exCtrl_q;
        if (flush) begin
            exValid_d = 1'b0;
        end else if (if_valid && id_ready) begin
            exValid_d  = 1'b1;
            exPc_d     = if_pc;
            exRs1_d    = rs1Val;
            exRs2_d    = rs2Val;
            exImm_d    = immD;
            exRd_d     = rdIdx;
            exOpBase_d = opBaseD;
            exOpExt_d  = opExtD;
            exCtrl_d   = ctrlD;
        end else if (ex_ready) begin
            exValid_d = 1'b0;
        end
    end

    // ID/EX register update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exValid_q  <= 1'b0;
            exPc_q     <= '0;
            exRs1_q    <= '0;
            exRs2_q    <= '0;
            exImm_q    <= '0;
            exRd_q     <= '0;
            exOpBase_q <= '0;
            exOpExt_q  <= '0;
            exCtrl_q   <= '0;
        end else begin
            exValid_q  <= exValid_d;
            exPc_q     <= exPc_d;
            exRs1_q    <= exRs1_d;
            exRs2_q    <= exRs2_d;
            exImm_q    <= exImm_d;
            exRd_q     <= exRd_d;
            exOpBase_q <= exOpBase_d;
            exOpExt_q  <= exOpExt_d;
            exCtrl_q   <= exCtrl_d;
        end
    end

    // Register file write port; x0 is never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we && wb_rd != 5'd0) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    assign ex_valid       = exValid_q;
    assign ex_pc          = exPc_q;
    assign ex_rs1_val     = exRs1_q;
    assign ex_rs2_val     = exRs2_q;
    assign ex_imm         = exImm_q;
    assign ex_rd          = exRd_q;
    assign ex_alu_op_base = exOpBase_q;
    assign ex_alu_op_ext  = exOpExt_q;
    assign ex_ctrl        = exCtrl_q;

endmodule
